ex_mem_stage_reg: RTL and testbench

- Parametrised EX/MEM pipeline register for the pipelined CPU, placed between the ALU/branch-adder stage and the data-memory stage.
- Adds a valid/ready handshake with a one-entry skid buffer, so a MEM-side stall (e.g. multi-cycle data memory) back-pressures EX without dropping an instruction.
- Adds a synchronous flush for branch squash, plus a registered branch-taken decision supporting both beq and bne.

---
 rtl/ex_mem_stage_reg.sv | 117 +++++++++++
 tb/tb_ex_mem_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a branch-taken decision registered alongside each entry.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  input  logic              Mem2Reg_i,
  input  logic              Branch_i,
  input  logic              BranchNe_i,
  input  logic [DATA_W-1:0] AddResult_i,
  input  logic              Zero_i,
  input  logic [DATA_W-1:0] ALU_data_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              RegWrite_o,
  output logic              MemWrite_o,
  output logic              MemRead_o,
  output logic              Mem2Reg_o,
  output logic              Branch_o,
  output logic [DATA_W-1:0] AddResult_o,
  output logic              Zero_o,
  output logic [DATA_W-1:0] ALU_data_o,
  output logic [DATA_W-1:0] writeData_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              branch_taken_o
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic              mem2reg;
    logic              branch;
    logic              taken;
    logic [DATA_W-1:0] add_result;
    logic              zero;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] rd_addr;
  } entry_t;

  entry_t in_e, m_q, s_q;
  logic   m_v, s_v;
  logic   accept, consume;

  // Taken is resolved on capture so it travels with the entry through the skid slot.
  always_comb begin
    in_e            = '0;
    in_e.reg_write  = RegWrite_i;
    in_e.mem_write  = MemWrite_i;
    in_e.mem_read   = MemRead_i;
    in_e.mem2reg    = Mem2Reg_i;
    in_e.branch     = Branch_i;
    in_e.taken      = Branch_i & (Zero_i ^ BranchNe_i);
    in_e.add_result = AddResult_i;
    in_e.zero       = Zero_i;
    in_e.alu_data   = ALU_data_i;
    in_e.write_data = writeData_i;
    in_e.rd_addr    = RDaddr_i;
  end

  assign in_ready_o  = ~s_v;
  assign out_valid_o = m_v;
  assign accept      = in_valid_i & ~s_v;
  assign consume     = m_v & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_q <= '0;
      s_q <= '0;
    end else if (flush_i) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (!m_v || consume) begin
      // Skid entry always drains first to keep program order.
      if (s_v) begin
        m_q <= s_q;
        m_v <= 1'b1;
        s_v <= 1'b0;
      end else if (accept) begin
        m_q <= in_e;
        m_v <= 1'b1;
      end else begin
        m_v <= 1'b0;
      end
    end else if (accept) begin
      s_q <= in_e;
      s_v <= 1'b1;
    end
  end

  // Bubbles must never write state downstream.
  assign RegWrite_o     = m_v & m_q.reg_write;
  assign MemWrite_o     = m_v & m_q.mem_write;
  assign MemRead_o      = m_v & m_q.mem_read;
  assign Mem2Reg_o      = m_v & m_q.mem2reg;
  assign Branch_o       = m_v & m_q.branch;
  assign branch_taken_o = m_v & m_q.taken;
  assign AddResult_o    = m_q.add_result;
  assign Zero_o         = m_q.zero;
  assign ALU_data_o     = m_q.alu_data;
  assign writeData_o    = m_q.write_data;
  assign RDaddr_o       = m_q.rd_addr;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg: driver queues expected entries,
// a negedge monitor pops and compares on every consumed output.
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic        rw, mw, mr, m2r, br, taken;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic        RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i, BranchNe_i, Zero_i;
  logic [31:0] AddResult_i, ALU_data_i, writeData_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o, Zero_o, branch_taken_o;
  logic [31:0] AddResult_o, ALU_data_o, writeData_o;
  logic [4:0]  RDaddr_o;

  ex_mem_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .Mem2Reg_i(Mem2Reg_i), .Branch_i(Branch_i), .BranchNe_i(BranchNe_i),
    .AddResult_i(AddResult_i), .Zero_i(Zero_i), .ALU_data_i(ALU_data_i),
    .writeData_i(writeData_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
    .Mem2Reg_o(Mem2Reg_o), .Branch_o(Branch_o), .AddResult_o(AddResult_o),
    .Zero_o(Zero_o), .ALU_data_o(ALU_data_o), .writeData_o(writeData_o),
    .RDaddr_o(RDaddr_o), .branch_taken_o(branch_taken_o)
  );

  always #5 clk_i = ~clk_i;

  ent_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: out_ready_i is only changed just after posedge, so the negedge
  // value is the one the next posedge will see.
  always @(negedge clk_i) begin
    ent_t act, e;
    if (!rst_i && out_valid_o && out_ready_i) begin
      act = '{rw:RegWrite_o, mw:MemWrite_o, mr:MemRead_o, m2r:Mem2Reg_o, br:Branch_o,
              taken:branch_taken_o, add:AddResult_o, zero:Zero_o, alu:ALU_data_o,
              wd:writeData_o, rd:RDaddr_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL out_entry: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] ctl,
                              input logic zero, input logic taken);
    ent_t e;
    e.rw = ctl[4]; e.mw = ctl[3]; e.mr = ctl[2]; e.m2r = ctl[1]; e.br = ctl[0];
    e.taken = taken; e.zero = zero; e.alu = alu;
    e.add = alu + 32'h1000; e.wd = ~alu; e.rd = alu[4:0] ^ 5'h15;
    return e;
  endfunction

  task automatic drive(input ent_t e, input logic bne);
    in_valid_i = 1'b1;
    RegWrite_i = e.rw; MemWrite_i = e.mw; MemRead_i = e.mr; Mem2Reg_i = e.m2r;
    Branch_i = e.br; BranchNe_i = bne; Zero_i = e.zero;
    AddResult_i = e.add; ALU_data_i = e.alu; writeData_i = e.wd; RDaddr_i = e.rd;
  endtask

  // Offer for one cycle; entry is expected only if the stage will take it.
  task automatic offer(input ent_t e, input logic bne);
    drive(e, bne);
    if (in_ready_o && !flush_i && !rst_i) exp_q.push_back(e);
    step();
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(mk(32'hDEAD, 5'b11111, 1'b1, 1'b1), 1'b0);
    step(); step();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_ctrl", {RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o, branch_taken_o}, 0);
    chk("rst_payload", {AddResult_o, ALU_data_o} | {32'h0, writeData_o} | {59'h0, RDaddr_o}, 0);
    rst_i = 1'b0;

    // First accept: valid one cycle later.
    offer(mk(32'h1, 5'b10000, 1'b0, 1'b0), 1'b0);
    idle();
    chk("first_latency", out_valid_o, 1);
    step();

    // Streaming at full rate.
    chk("stream_rdy0", in_ready_o, 1);
    offer(mk(32'h10, 5'b10010, 1'b0, 1'b0), 1'b0);
    chk("stream_rdy1", in_ready_o, 1);
    offer(mk(32'h20, 5'b01000, 1'b1, 1'b0), 1'b0);
    chk("stream_rdy2", in_ready_o, 1);
    offer(mk(32'h30, 5'b00110, 1'b0, 1'b0), 1'b0);
    chk("stream_rdy3", in_ready_o, 1);
    idle(); step(); step();

    // Stall / skid: 0xB is a taken bne branch parked in the skid slot.
    out_ready_i = 1'b0;
    offer(mk(32'hA, 5'b10000, 1'b1, 1'b0), 1'b0);
    offer(mk(32'hB, 5'b00001, 1'b0, 1'b1), 1'b1);
    idle();
    chk("skid_in_ready", in_ready_o, 0);
    chk("skid_hold_a", ALU_data_o, 32'hA);
    step();
    chk("skid_hold_a2", ALU_data_o, 32'hA);
    chk("skid_ready_low", in_ready_o, 0);
    out_ready_i = 1'b1;
    step();
    chk("skid_b_out", ALU_data_o, 32'hB);
    chk("skid_ready_back", in_ready_o, 1);
    step(); step();

    // Branch decisions.
    offer(mk(32'h40, 5'b00001, 1'b1, 1'b1), 1'b0);
    offer(mk(32'h44, 5'b00001, 1'b0, 1'b1), 1'b1);
    offer(mk(32'h48, 5'b00001, 1'b1, 1'b0), 1'b1);
    offer(mk(32'h4C, 5'b10000, 1'b1, 1'b0), 1'b0);
    idle(); step(); step();

    // Flush with both slots full and a new store offered.
    out_ready_i = 1'b0;
    offer(mk(32'hF1, 5'b01000, 1'b0, 1'b0), 1'b0);
    offer(mk(32'hF2, 5'b01000, 1'b0, 1'b0), 1'b0);
    flush_i = 1'b1;
    offer(mk(32'hF3, 5'b01000, 1'b0, 1'b0), 1'b0);
    exp_q.delete();
    flush_i = 1'b0; idle();
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_memwrite", MemWrite_o, 0);
    chk("flush_in_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    step(); step();
    offer(mk(32'h50, 5'b10000, 1'b0, 1'b0), 1'b0);
    idle(); step(); step();

    // Bubble gating.
    drive(mk(32'h60, 5'b10000, 1'b0, 1'b0), 1'b0);
    in_valid_i = 1'b0;
    step();
    chk("bubble_regwrite", RegWrite_o, 0);
    chk("bubble_valid", out_valid_o, 0);
    step();

    // Reset mid-stall drops both entries and clears payload.
    out_ready_i = 1'b0;
    offer(mk(32'h70, 5'b11000, 1'b0, 1'b0), 1'b0);
    offer(mk(32'h74, 5'b11000, 1'b0, 1'b0), 1'b0);
    idle();
    rst_i = 1'b1;
    step();
    exp_q.delete();
    rst_i = 1'b0;
    chk("rst_stall_valid", out_valid_o, 0);
    chk("rst_stall_ready", in_ready_o, 1);
    chk("rst_stall_payload", ALU_data_o, 0);
    out_ready_i = 1'b1;
    offer(mk(32'h80, 5'b00100, 1'b1, 1'b0), 1'b0);
    idle(); step(); step();

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
